bk_sector_seq: RTL and testbench

Backup-RAM transfer sequencer for the SMS core. It owns the SD sector handshake between the HPS block interface and the 32 KiB nvram dual-port buffer. It arms itself when a writable save image is mounted at the end of a ROM download, then streams one save slot of 2^SECT_BITS 512-byte sectors on a load or save request. It also reports busy, loading and dirty status to the core reset and LED logic.

---
 rtl/bk_pkg.sv | 14 +
 rtl/bk_autosave_timer.sv | 31 +++
 rtl/bk_sector_seq.sv | 188 ++++++++++++++++++
 tb/tb_bk_sector_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM sector sequencer.
package bk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK_WAIT = 2'd1,
        ACK_END  = 2'd2
    } bk_state_t;

    localparam int BK_SECT_BITS = 6;
    localparam int BK_SLOT_BITS = 2;
    localparam int SECTOR_BYTES = 512;

endpackage

// File: rtl/bk_autosave_timer.sv
// Idle timer for autosave: restarts on every nvram write and fires one
// cycle once AUTOSAVE_CYC quiet cycles have elapsed while armed.
module bk_autosave_timer #(
    parameter int AUTOSAVE_CYC = 107386350
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_we,
    input  logic i_arm,
    output logic o_fire
);

    localparam int CNT_W = $clog2(AUTOSAVE_CYC) + 1;
    localparam logic [CNT_W-1:0] LIM = CNT_W'(AUTOSAVE_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Counter saturates at LIM so a long idle period waits for the arm condition.
    assign o_fire = i_arm & ~i_we & (r_cnt == LIM);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_we || o_fire) begin
            r_cnt <= '0;
        end else if (r_cnt != LIM) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bk_sector_seq.sv
// Backup-RAM sector sequencer: streams one save slot between HPS and nvram.
// Define BK_AUTOSAVE_EN to enable the idle-timer autosave.
module bk_sector_seq
    import bk_pkg::*;
#(
    parameter int SECT_BITS    = BK_SECT_BITS,
    parameter int SLOT_BITS    = BK_SLOT_BITS,
    parameter int AUTOSAVE_CYC = 107386350
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 downloading,
    input  logic                 img_mounted,
    input  logic                 img_readonly,
    input  logic                 img_size_nz,
    input  logic                 load_req,
    input  logic                 save_req,
    input  logic [SLOT_BITS-1:0] slot,
    input  logic                 nvram_we,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    output logic                 bk_ena,
    output logic                 bk_loading,
    output logic                 busy,
    output logic                 done,
    output logic                 dirty
);

    bk_state_t   r_state, w_state_n;
    logic        r_dl_d, r_load_d, r_save_d, r_ack_d;
    logic [31:0] r_sd_lba, w_lba_n;
    logic        r_sd_rd, w_rd_n;
    logic        r_sd_wr, w_wr_n;
    logic        r_bk_loading, w_loading_n;
    logic        r_busy, w_busy_n;
    logic        r_done, w_done_n;
    logic        r_bk_ena, r_dirty;
    logic        w_clr_dirty;

    logic        w_dl_rise, w_load_rise, w_save_rise, w_ack_rise, w_ack_fall;
    logic        w_auto_fire, w_trig, w_last;
    logic [31:0] w_slot_base;

    assign w_dl_rise   = downloading & ~r_dl_d;
    assign w_load_rise = load_req & ~r_load_d;
    assign w_save_rise = save_req & ~r_save_d;
    assign w_ack_rise  = sd_ack & ~r_ack_d;
    assign w_ack_fall  = ~sd_ack & r_ack_d;
    assign w_trig      = r_bk_ena & (w_load_rise | w_save_rise | w_auto_fire);
    assign w_last      = &r_sd_lba[SECT_BITS-1:0];
    assign w_slot_base = 32'({slot, {SECT_BITS{1'b0}}});

`ifdef BK_AUTOSAVE_EN
    logic w_auto_arm;
    assign w_auto_arm = (r_state == IDLE) & r_bk_ena & r_dirty & ~downloading;

    bk_autosave_timer #(
        .AUTOSAVE_CYC (AUTOSAVE_CYC)
    ) u_autosave_timer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_we    (nvram_we),
        .i_arm   (w_auto_arm),
        .o_fire  (w_auto_fire)
    );
`else
    logic w_unused_cfg;
    assign w_auto_fire  = 1'b0;
    assign w_unused_cfg = (AUTOSAVE_CYC != 0);
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dl_d   <= 1'b0;
            r_load_d <= 1'b0;
            r_save_d <= 1'b0;
            r_ack_d  <= 1'b0;
        end else begin
            r_dl_d   <= downloading;
            r_load_d <= load_req;
            r_save_d <= save_req;
            r_ack_d  <= sd_ack;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sd_lba     <= '0;
            r_sd_rd      <= 1'b0;
            r_sd_wr      <= 1'b0;
            r_bk_loading <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_sd_lba     <= w_lba_n;
            r_sd_rd      <= w_rd_n;
            r_sd_wr      <= w_wr_n;
            r_bk_loading <= w_loading_n;
            r_busy       <= w_busy_n;
            r_done       <= w_done_n;
        end
    end

    // A new download always kills the transfer, whatever the state.
    always_comb begin
        w_state_n   = r_state;
        w_lba_n     = r_sd_lba;
        w_rd_n      = r_sd_rd;
        w_wr_n      = r_sd_wr;
        w_loading_n = r_bk_loading;
        w_busy_n    = r_busy;
        w_done_n    = 1'b0;
        w_clr_dirty = 1'b0;
        if (w_dl_rise) begin
            w_state_n   = IDLE;
            w_rd_n      = 1'b0;
            w_wr_n      = 1'b0;
            w_loading_n = 1'b0;
            w_busy_n    = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        w_lba_n     = w_slot_base;
                        w_rd_n      = w_load_rise;
                        w_wr_n      = ~w_load_rise;
                        w_loading_n = w_load_rise;
                        w_busy_n    = 1'b1;
                        w_state_n   = ACK_WAIT;
                    end
                end
                ACK_WAIT: begin
                    if (w_ack_rise) begin
                        w_rd_n    = 1'b0;
                        w_wr_n    = 1'b0;
                        w_state_n = ACK_END;
                    end
                end
                ACK_END: begin
                    if (w_ack_fall) begin
                        if (w_last) begin
                            w_done_n    = 1'b1;
                            w_busy_n    = 1'b0;
                            w_loading_n = 1'b0;
                            w_clr_dirty = 1'b1;
                            w_state_n   = IDLE;
                        end else begin
                            w_lba_n   = r_sd_lba + 32'd1;
                            w_rd_n    = r_bk_loading;
                            w_wr_n    = ~r_bk_loading;
                            w_state_n = ACK_WAIT;
                        end
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    // Arming: set wins over the download-rise clear only when both coincide.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_bk_ena <= 1'b0;
            r_dirty  <= 1'b0;
        end else begin
            if (downloading && img_mounted && img_size_nz && !img_readonly) begin
                r_bk_ena <= 1'b1;
            end else if (w_dl_rise) begin
                r_bk_ena <= 1'b0;
            end
            r_dirty <= (r_dirty & ~w_clr_dirty) | (nvram_we & ~r_bk_loading);
        end
    end

    assign sd_lba     = r_sd_lba;
    assign sd_rd      = r_sd_rd;
    assign sd_wr      = r_sd_wr;
    assign bk_ena     = r_bk_ena;
    assign bk_loading = r_bk_loading;
    assign busy       = r_busy;
    assign done       = r_done;
    assign dirty      = r_dirty;

endmodule

// File: tb/tb_bk_sector_seq.sv
// Directed bench for bk_sector_seq with a simple HPS acknowledge model.
module tb_bk_sector_seq;

    logic        clk_sys = 1'b0;
    logic        reset, downloading, img_mounted, img_readonly, img_size_nz;
    logic        load_req, save_req, nvram_we, sd_ack;
    logic [1:0]  slot;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, bk_ena, bk_loading, busy, done, dirty;

    int tests = 0;
    int fails = 0;

    int          sect_cnt, bad_lba, rd_cnt, wr_cnt, both_cnt, ack_err;
    int          done_cnt, done_bad, ld_low;
    logic [31:0] exp_base;
    bit          hps_en, ld_mon;
    logic        prev_busy;

    typedef struct {
        logic dl;
        logic mnt;
        logic ro;
        logic nz;
        logic ena;
    } arm_vec_t;

    arm_vec_t arm_tbl[9];

    always #5 clk_sys = ~clk_sys;

    bk_sector_seq #(
        .SECT_BITS    (6),
        .SLOT_BITS    (2),
        .AUTOSAVE_CYC (100)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .downloading  (downloading),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size_nz  (img_size_nz),
        .load_req     (load_req),
        .save_req     (save_req),
        .slot         (slot),
        .nvram_we     (nvram_we),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .bk_ena       (bk_ena),
        .bk_loading   (bk_loading),
        .busy         (busy),
        .done         (done),
        .dirty        (dirty)
    );

    // HPS model: acks each sector request, logs address and direction.
    always begin
        @(negedge clk_sys);
        if (hps_en && (sd_rd === 1'b1 || sd_wr === 1'b1) && sd_ack === 1'b0) begin
            if (sd_lba !== exp_base + 32'(sect_cnt)) bad_lba++;
            if (sd_rd && sd_wr) both_cnt++;
            else if (sd_rd)     rd_cnt++;
            else                wr_cnt++;
            sect_cnt++;
            repeat (2) @(negedge clk_sys);
            sd_ack = 1'b1;
            @(negedge clk_sys);
            if (sd_rd !== 1'b0 || sd_wr !== 1'b0) ack_err++;
            repeat (2) @(negedge clk_sys);
            sd_ack = 1'b0;
        end
    end

    always @(negedge clk_sys) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (busy !== 1'b0 || prev_busy !== 1'b1) done_bad++;
        end
        if (ld_mon && busy === 1'b1 && bk_loading !== 1'b1) ld_low++;
        prev_busy = busy;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon(input logic [31:0] base);
        sect_cnt = 0; bad_lba = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
        ack_err = 0; done_cnt = 0; ld_low = 0;
        exp_base = base;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_sys);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: timeout, busy=%b required=0", nm, busy);
        end
        @(negedge clk_sys);
    endtask

    task automatic chk_xfer(input string nm, input int exp_rd, input int exp_wr);
        chk({nm, "_sectors"}, sect_cnt, 64);
        chk({nm, "_rd_cnt"}, rd_cnt, exp_rd);
        chk({nm, "_wr_cnt"}, wr_cnt, exp_wr);
        chk({nm, "_both"}, both_cnt, 0);
        chk({nm, "_bad_lba"}, bad_lba, 0);
        chk({nm, "_ack_drop"}, ack_err, 0);
        chk({nm, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        arm_tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        arm_tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        arm_tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        arm_tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        arm_tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        arm_tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        arm_tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        arm_tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        arm_tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; downloading = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
        img_size_nz = 1'b0; load_req = 1'b0; save_req = 1'b0; nvram_we = 1'b0;
        sd_ack = 1'b0; slot = 2'd0; hps_en = 1'b0; ld_mon = 1'b0; done_bad = 0;
        clear_mon(32'h0);
        repeat (3) @(negedge clk_sys);
        chk("rst_lba", sd_lba, 32'h0);
        chk("rst_rd", sd_rd, 0);
        chk("rst_wr", sd_wr, 0);
        chk("rst_ena", bk_ena, 0);
        chk("rst_loading", bk_loading, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dirty", dirty, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            downloading  = arm_tbl[i].dl;
            img_mounted  = arm_tbl[i].mnt;
            img_readonly = arm_tbl[i].ro;
            img_size_nz  = arm_tbl[i].nz;
            @(negedge clk_sys);
            chk($sformatf("arm_row%0d", i), bk_ena, arm_tbl[i].ena);
        end
        img_size_nz = 1'b0;
        hps_en = 1'b1;

        nvram_we = 1'b1;
        @(negedge clk_sys);
        nvram_we = 1'b0;
        chk("dirty_set", dirty, 1);

        // Load slot 2
        clear_mon(32'h80); ld_mon = 1'b1;
        slot = 2'd2; load_req = 1'b1;
        @(negedge clk_sys);
        chk("load_first_rd", sd_rd, 1);
        chk("load_first_wr", sd_wr, 0);
        chk("load_first_lba", sd_lba, 32'h80);
        chk("load_first_busy", busy, 1);
        chk("load_first_loading", bk_loading, 1);
        slot = 2'd0;
        wait_idle("load_idle");
        ld_mon = 1'b0;
        chk_xfer("load", 64, 0);
        chk("load_loading_held", ld_low, 0);
        chk("load_loading_end", bk_loading, 0);
        chk("load_dirty_clr", dirty, 0);
        load_req = 1'b0;

        // Save slot 3
        nvram_we = 1'b1;
        @(negedge clk_sys);
        nvram_we = 1'b0;
        chk("save_pre_dirty", dirty, 1);
        clear_mon(32'hC0);
        slot = 2'd3; save_req = 1'b1;
        @(negedge clk_sys);
        chk("save_first_wr", sd_wr, 1);
        chk("save_first_rd", sd_rd, 0);
        chk("save_first_lba", sd_lba, 32'hC0);
        chk("save_first_loading", bk_loading, 0);
        wait_idle("save_idle");
        chk_xfer("save", 0, 64);
        chk("save_dirty_clr", dirty, 0);
        save_req = 1'b0;
        @(negedge clk_sys);

        // Simultaneous load and save: load wins
        clear_mon(32'h40);
        slot = 2'd1; load_req = 1'b1; save_req = 1'b1;
        @(negedge clk_sys);
        chk("both_first_rd", sd_rd, 1);
        chk("both_first_wr", sd_wr, 0);
        wait_idle("both_idle");
        chk_xfer("both", 64, 0);
        load_req = 1'b0; save_req = 1'b0;
        @(negedge clk_sys);

        // Save request mid-load is dropped
        clear_mon(32'h0);
        slot = 2'd0; load_req = 1'b1;
        repeat (100) @(negedge clk_sys);
        chk("ovl_mid_busy", busy, 1);
        save_req = 1'b1;
        wait_idle("ovl_idle");
        chk_xfer("ovl", 64, 0);
        repeat (10) @(negedge clk_sys);
        chk("ovl_no_requeue", busy, 0);
        load_req = 1'b0; save_req = 1'b0;
        @(negedge clk_sys);

        // Abort during sector 10
        clear_mon(32'h40);
        slot = 2'd1; load_req = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_sys);
            if (sect_cnt >= 11) break;
        end
        chk("abort_reached", sect_cnt >= 11, 1);
        downloading = 1'b1;
        @(negedge clk_sys);
        chk("abort_rd", sd_rd, 0);
        chk("abort_wr", sd_wr, 0);
        chk("abort_busy", busy, 0);
        chk("abort_loading", bk_loading, 0);
        chk("abort_ena", bk_ena, 0);
        repeat (20) @(negedge clk_sys);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_stay_idle", busy, 0);
        load_req = 1'b0;

`ifdef BK_AUTOSAVE_EN
        img_mounted = 1'b1; img_size_nz = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0; img_size_nz = 1'b0; downloading = 1'b0;
        @(negedge clk_sys);
        chk("rearm_ena", bk_ena, 1);

        begin
            int start;
            clear_mon(32'h80);
            slot = 2'd2; nvram_we = 1'b1;
            @(negedge clk_sys);
            nvram_we = 1'b0; start = -1;
            for (int c = 1; c < 300; c++) begin
                @(negedge clk_sys);
                if (sd_wr === 1'b1) begin
                    start = c;
                    break;
                end
            end
            chk("auto1_start", start, 100);
            wait_idle("auto1_idle");
            chk_xfer("auto1", 0, 64);
            chk("auto1_dirty", dirty, 0);

            clear_mon(32'h80);
            nvram_we = 1'b1;
            @(negedge clk_sys);
            nvram_we = 1'b0; start = -1;
            for (int c = 1; c < 400; c++) begin
                @(negedge clk_sys);
                if (sd_wr === 1'b1) begin
                    start = c;
                    break;
                end
                nvram_we = (c == 49);
            end
            nvram_we = 1'b0;
            chk("auto2_start", start, 150);
            wait_idle("auto2_idle");
            chk_xfer("auto2", 0, 64);
        end
`endif

        chk("done_align", done_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
